// File: rtl/tp_stretch_sel_pkg.sv
// rtl/tp_stretch_sel_pkg.sv - shared constants and types for the test-point selector
//
// Purpose:
//   Mode encodings for the test-point mux, the mode-change FSM state type and
//   the default timing parameters used by tp_stretch_sel and tp_pulse_stretch.
//
// Ports: none (package).

package tp_pkg;

    // Test-point views selectable at run time
    localparam logic [1:0] TP_MODE_LVL = 2'd0;   // raw levels
    localparam logic [1:0] TP_MODE_STR = 2'd1;   // stretched events
    localparam logic [1:0] TP_MODE_MIX = 2'd2;   // stretched high half, levels low half
    localparam logic [1:0] TP_MODE_CNT = 2'd3;   // EVT_IN[0] edge count

    // Mode-change FSM
    typedef enum logic {
        TP_RUN  = 1'b0,
        TP_BLNK = 1'b1
    } tp_state_e;

    // Default sizing
    localparam int TP_NIN_DEF     = 16;
    localparam int TP_STRETCH_DEF = 8;
    localparam int TP_BLANK_DEF   = 2;

    // Width of the per-bit stretch counter and the blanking counter
    localparam int TP_STR_CNT_W   = 8;
    localparam int TP_BLANK_CNT_W = 4;

    // Width of the event counter shown in TP_MODE_CNT
    localparam int TP_EVT_CNT_W   = 16;

endpackage

// File: rtl/tp_pulse_stretch.sv
// rtl/tp_pulse_stretch.sv - one-bit rising-edge detector with a retriggerable stretcher
//
// Purpose:
//   Detects a rising edge on a single event strobe and holds str_o high for
//   STRETCH cycles. A new edge during the hold reloads the counter so the
//   pulse is extended rather than counted twice.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-high reset
//   evt_i   in   event strobe (only rising edges matter)
//   edge_o  out  combinational one-cycle edge strobe (evt_i=1, previous=0)
//   str_o   out  stretched pulse, high while the hold counter is nonzero

module tp_pulse_stretch
    import tp_pkg::*;
#(
    parameter int STRETCH = TP_STRETCH_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic evt_i,
    output logic edge_o,
    output logic str_o
);

    logic                    prev_q;
    logic [TP_STR_CNT_W-1:0] cnt_q;
    logic [TP_STR_CNT_W-1:0] cnt_d;

    // prev_q resets high so an input already high at reset release is not
    // seen as an edge.
    assign edge_o = evt_i & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_o) begin
            cnt_d = TP_STR_CNT_W'(STRETCH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TP_STR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            prev_q <= evt_i;
            cnt_q  <= cnt_d;
        end
    end

    assign str_o = (cnt_q != '0);

endmodule

// File: rtl/tp_stretch_sel.sv
// rtl/tp_stretch_sel.sv - debug event stretcher and test-point view selector
//
// Purpose:
//   Stretches single-cycle event strobes, multiplexes levels / stretched
//   events / a mix / an event count onto a registered test-point word, lets
//   software change the view through a load/ack handshake with output
//   blanking, and emits a one-cycle scope trigger on a selectable event bit.
//
// Ports:
//   CLK       in   system clock
//   RST       in   asynchronous active-high reset
//   EVT_IN    in   [NIN] event strobes, rising edges used
//   LVL_IN    in   [NIN] level signals
//   SEL_LD    in   one-cycle request to load SEL_DATA as the new mode
//   SEL_DATA  in   [2] requested mode
//   TRIG_SEL  in   [4] EVT_IN bit index driving TRIG_OUT
//   SEL_ACK   out  one-cycle pulse when the new mode is live
//   TRIG_OUT  out  one-cycle trigger following an edge on EVT_IN[TRIG_SEL]
//   TP_OUT    out  [NIN] registered test-point word

module tp_stretch_sel
    import tp_pkg::*;
#(
    parameter int NIN     = TP_NIN_DEF,
    parameter int STRETCH = TP_STRETCH_DEF,
    parameter int BLANK   = TP_BLANK_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NIN-1:0] EVT_IN,
    input  logic [NIN-1:0] LVL_IN,
    input  logic           SEL_LD,
    input  logic [1:0]     SEL_DATA,
    input  logic [3:0]     TRIG_SEL,
    output logic           SEL_ACK,
    output logic           TRIG_OUT,
    output logic [NIN-1:0] TP_OUT
);

    localparam int HALF = NIN / 2;

    // ------------------------------------------------------------------
    // Per-bit edge detect and stretch
    // ------------------------------------------------------------------
    logic [NIN-1:0] evt_edge;
    logic [NIN-1:0] str;

    for (genvar g = 0; g < NIN; g++) begin : g_bit
        tp_pulse_stretch #(
            .STRETCH (STRETCH)
        ) u_str (
            .clk_i  (CLK),
            .rst_i  (RST),
            .evt_i  (EVT_IN[g]),
            .edge_o (evt_edge[g]),
            .str_o  (str[g])
        );
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tp_state_e                 state_q;
    logic [1:0]                mode_q;
    logic [1:0]                pend_q;
    logic [TP_BLANK_CNT_W-1:0] blank_q;
    logic                      sel_ack_q;
    logic                      trig_q;
    logic [NIN-1:0]            tp_q;
    logic [NIN-1:0]            tp_d;
    logic [TP_EVT_CNT_W-1:0]   evt_cnt_q;
    logic [TP_EVT_CNT_W-1:0]   evt_cnt_d;

    // The cycle in which the blank counter has run out is the cycle the
    // pending mode becomes live. The output register is loaded with the new
    // view in that same cycle so the first non-blank word is already the new
    // mode and SEL_ACK lines up with it.
    logic       going_live;
    logic [1:0] view_mode;
    logic       live_cnt_clr;

    assign going_live   = (state_q == TP_BLNK) && (blank_q == '0);
    assign view_mode    = going_live ? pend_q : mode_q;
    assign live_cnt_clr = going_live && (pend_q == TP_MODE_CNT);

    // ------------------------------------------------------------------
    // Event counter on EVT_IN[0]; wraps naturally at the top
    // ------------------------------------------------------------------
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (live_cnt_clr) begin
            evt_cnt_d = '0;
        end else if (evt_edge[0]) begin
            evt_cnt_d = evt_cnt_q + TP_EVT_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Test-point view mux and blanking
    // ------------------------------------------------------------------
    always_comb begin
        tp_d = '0;
        if (state_q == TP_RUN || going_live) begin
            unique case (view_mode)
                TP_MODE_LVL: tp_d = LVL_IN;
                TP_MODE_STR: tp_d = str;
                TP_MODE_MIX: tp_d = {str[NIN-1:HALF], LVL_IN[HALF-1:0]};
                TP_MODE_CNT: tp_d = live_cnt_clr ? '0 : NIN'(evt_cnt_q);
                default:     tp_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mode-change FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= TP_RUN;
            mode_q    <= TP_MODE_LVL;
            pend_q    <= TP_MODE_LVL;
            blank_q   <= '0;
            sel_ack_q <= 1'b0;
            trig_q    <= 1'b0;
            tp_q      <= '0;
            evt_cnt_q <= '0;
        end else begin
            sel_ack_q <= 1'b0;
            trig_q    <= evt_edge[TRIG_SEL];
            tp_q      <= tp_d;
            evt_cnt_q <= evt_cnt_d;

            unique case (state_q)
                TP_RUN: begin
                    if (SEL_LD) begin
                        pend_q  <= SEL_DATA;
                        blank_q <= TP_BLANK_CNT_W'(BLANK);
                        state_q <= TP_BLNK;
                    end
                end
                TP_BLNK: begin
                    // SEL_LD is deliberately not looked at here.
                    if (blank_q == '0) begin
                        mode_q    <= pend_q;
                        sel_ack_q <= 1'b1;
                        state_q   <= TP_RUN;
                    end else begin
                        blank_q <= blank_q - TP_BLANK_CNT_W'(1);
                    end
                end
                default: state_q <= TP_RUN;
            endcase
        end
    end

    assign SEL_ACK  = sel_ack_q;
    assign TRIG_OUT = trig_q;
    assign TP_OUT   = tp_q;

endmodule
